// File: rtl/coor_pkg.sv
// coor_pkg: shared field split, checker state encoding and raster-order helpers for the coordinate path
package coor_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    // Raster order is row-major: col advances fastest, row advances on col wrap
    localparam bit RASTER_COL_FASTEST = 1'b1;
    typedef enum logic [1:0] {IDLE, RECV, DONE} chk_state_t;
    // Bit position where the row field starts; col occupies the bits below it
    function automatic int row_lsb(input int dw);
        return dw / 2;
    endfunction
    // Counter width able to hold any row or col index, never narrower than 1 bit
    function automatic int ctr_width(input int rows, input int cols);
        int m;
        m = (rows > cols) ? rows : cols;
        m = (m > 2) ? m : 2;
        return $clog2(m);
    endfunction
endpackage

// File: rtl/coor_raster_counter.sv
// coor_raster_counter: row/col raster position counter with clear, enable, col wrap and last-position flag
module coor_raster_counter #(
    parameter int ROW = 4,
    parameter int COL = 6,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic         is_last
);
    localparam logic [W-1:0] ROW_MAX = W'(ROW - 1);
    localparam logic [W-1:0] COL_MAX = W'(COL - 1);

    assign is_last = (row == ROW_MAX) && (col == COL_MAX);

    // Step col each enabled cycle; wrap col into the next row, and wrap the whole frame after the last position
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            col <= (col == COL_MAX) ? '0 : col + W'(1);
            row <= (col != COL_MAX) ? row : (is_last ? '0 : row + W'(1));
        end
endmodule

// File: rtl/coor_stream_checker.sv
// coor_stream_checker: AXI-Stream sink that checks a {row,col} raster stream and reports per-frame pass/fail
module coor_stream_checker
    import coor_pkg::*;
#(
    parameter int ROW        = 4,
    parameter int COL        = 6,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_areset,
    input  logic                    start,
    input  logic                    hold,
    input  logic                    s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic                    frame_ok,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic [DATA_WIDTH/2-1:0] first_err_row,
    output logic [DATA_WIDTH/2-1:0] first_err_col
);
    localparam int HW = row_lsb(DATA_WIDTH);
    localparam int W  = ctr_width(ROW, COL);

    chk_state_t    state;
    logic [W-1:0]  exp_row;
    logic [W-1:0]  exp_col;
    logic          is_last;
    logic [HW-1:0] rx_row;
    logic [HW-1:0] rx_col;
    logic          acc;
    logic          bad;

    assign rx_row        = s_axis_tdata[DATA_WIDTH-1:HW];
    assign rx_col        = s_axis_tdata[HW-1:0];
    assign s_axis_tready = (state == RECV) && !hold;
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign bad           = (rx_row != HW'(exp_row)) || (rx_col != HW'(exp_col)) || (s_axis_tlast != is_last);

    coor_raster_counter #(.ROW(ROW), .COL(COL), .W(W)) u_ctr (
        .clk     (s_axis_aclk),
        .rst     (s_axis_areset),
        .clr     ((state == IDLE) && start),
        .en      (acc),
        .row     (exp_row),
        .col     (exp_col),
        .is_last (is_last)
    );

    // Frame FSM: arm on start, score each accepted beat, end on tlast or last expected position, publish result
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset)
        if (s_axis_areset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            frame_ok      <= 1'b0;
            err_count     <= '0;
            first_err_row <= '0;
            first_err_col <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state         <= RECV;
                    busy          <= 1'b1;
                    err_count     <= '0;
                    first_err_row <= '0;
                    first_err_col <= '0;
                end
                RECV: if (acc) begin
                    if (bad) begin
                        err_count <= (&err_count) ? err_count : err_count + CNT_WIDTH'(1);
                        if (err_count == '0) begin
                            first_err_row <= rx_row;
                            first_err_col <= rx_col;
                        end
                    end
                    if (s_axis_tlast || is_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    frame_ok <= (err_count == '0);
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_coor_stream_checker.sv
// tb_coor_stream_checker: directed frames with a result scoreboard popped on each done pulse
module tb_coor_stream_checker;
    localparam int ROW = 4;
    localparam int COL = 6;
    localparam int N   = ROW * COL;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hold;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        tready;
    logic        busy;
    logic        done;
    logic        frame_ok;
    logic [15:0] err_count;
    logic [15:0] first_err_row;
    logic [15:0] first_err_col;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int err;
        int ok;
        int fr;
        int fc;
    } res_t;
    res_t sb[$];

    always #5 clk = ~clk;

    coor_stream_checker #(.ROW(ROW), .COL(COL), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .start         (start),
        .hold          (hold),
        .s_axis_tvalid (tvalid),
        .s_axis_tdata  (tdata),
        .s_axis_tlast  (tlast),
        .s_axis_tready (tready),
        .busy          (busy),
        .done          (done),
        .frame_ok      (frame_ok),
        .err_count     (err_count),
        .first_err_row (first_err_row),
        .first_err_col (first_err_col)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every done pulse pops the oldest expected frame result
    always @(negedge clk) begin
        res_t e;
        if (done) begin
            if (sb.size() == 0) chk("unexpected_done", done, 0);
            else begin
                e = sb.pop_front();
                chk("err_count", err_count, e.err);
                if (e.err != 0) begin
                    chk("first_err_row", first_err_row, e.fr);
                    chk("first_err_col", first_err_col, e.fc);
                end
                @(posedge clk); #1;
                chk("frame_ok", frame_ok, e.ok);
            end
        end
    end

    task automatic run_frame(input int bad_idx, input logic [15:0] br, input logic [15:0] bc,
                             input int early, input bit drop_last, input bit bp,
                             input bit skip_start, input bit keep_start);
        logic [15:0] rr[N];
        logic [15:0] cc[N];
        logic        ll[N];
        res_t        e;
        int          n;
        int          i;
        int          cyc;
        bit          acc;
        n = (early >= 0) ? early + 1 : N;
        e.err = 0; e.fr = 0; e.fc = 0;
        for (int k = 0; k < n; k++) begin
            rr[k] = 16'(k / COL);
            cc[k] = 16'(k % COL);
            ll[k] = (k == N - 1);
            if (k == bad_idx) begin rr[k] = br; cc[k] = bc; end
            if (k == early) ll[k] = 1'b1;
            if (drop_last && k == N - 1) ll[k] = 1'b0;
            if (rr[k] != 16'(k / COL) || cc[k] != 16'(k % COL) || ll[k] != (k == N - 1)) begin
                if (e.err == 0) begin e.fr = rr[k]; e.fc = cc[k]; end
                e.err++;
            end
        end
        e.ok = (e.err == 0);
        sb.push_back(e);
        if (!skip_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = keep_start;
        end
        chk("busy_at_start", busy, 1);
        i = 0; cyc = 0;
        while (i < n && cyc < 200) begin
            hold   = bp && (cyc inside {[2:4], 6});
            tvalid = !bp || (cyc % 4 != 3);
            tdata  = {rr[i], cc[i]};
            tlast  = ll[i];
            #1;
            chk("tready_vs_hold", tready, !hold);
            acc = tvalid && tready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        tvalid = 1'b0; hold = 1'b0; tlast = 1'b0;
        chk("beats_accepted", i, n);
        chk("done_after_last", done, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        #1;
        chk("rst_tready", tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frame_ok", frame_ok, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err", {first_err_row, first_err_col}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_tready", tready, 0);

        run_frame(-1, 0, 0, -1, 0, 0, 0, 0);
        repeat (2) @(posedge clk); #1;

        run_frame(-1, 0, 0, -1, 0, 1, 0, 0);
        repeat (2) @(posedge clk); #1;

        run_frame(7, 16'd1, 16'd3, -1, 0, 0, 0, 0);
        repeat (2) @(posedge clk); #1;

        run_frame(-1, 0, 0, 9, 0, 0, 0, 1);
        @(posedge clk); #1;
        chk("rearm_idle", busy, 0);
        @(posedge clk); #1;
        chk("rearm_recv", busy, 1);
        start = 1'b0;
        run_frame(-1, 0, 0, -1, 0, 0, 1, 0);
        repeat (2) @(posedge clk); #1;

        run_frame(-1, 0, 0, -1, 1, 0, 0, 0);
        repeat (2) @(posedge clk); #1;

        run_frame(-1, 0, 0, -1, 0, 0, 0, 0);
        repeat (2) @(posedge clk); #1;
        chk("frame_ok_before_abort", frame_ok, 1);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tdata = {16'(k / COL), 16'(k % COL)};
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_tready", tready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_frame_ok", frame_ok, 0);
        chk("abort_err_count", err_count, 0);
        tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("abort_no_done", done, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
